// File: rtl/if_fetch_stage_if.sv
// IMEM read port bundle between the fetch stage and a synchronous-read IMEM.
// master: imem_en/imem_addr out, imem_rdata in; slave: the reverse.
interface if_fetch_stage_if;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;

    modport master (
        output imem_en,
        output imem_addr,
        input  imem_rdata
    );

    modport slave (
        input  imem_en,
        input  imem_addr,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_stage.sv
// IF stage: owns the fetch PC, drives a 1-cycle IMEM, holds one word on stall.
// Ports: clk, reset (async low), ena, redirect_req/pc, exc_req, imem (master), if_* outputs.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0004
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ena,
    input  logic               redirect_req,
    input  logic [31:0]        redirect_pc,
    input  logic               exc_req,
    if_fetch_stage_if.master   imem,
    output logic [31:0]        if_pc_out,
    output logic [31:0]        if_instr_out,
    output logic               if_valid,
    output logic               if_adel
);

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        STREAM = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] fetch_pc;
    logic [31:0] resp_pc;
    logic        resp_adel;
    logic [31:0] hold_instr;
    logic [31:0] hold_pc;
    logic        hold_adel;

    logic        v1;
    logic        hold_valid;
    logic        out_valid;
    logic        squash;
    logic        issue;
    logic        capture;
    logic        tgt_adel;
    logic [31:0] tgt;

    assign v1         = (state == STREAM);
    assign hold_valid = (state == HOLD);
    assign out_valid  = v1 | hold_valid;
    assign squash     = exc_req | redirect_req;

    // Exception beats redirect, redirect beats sequential fetch.
    always_comb begin
        tgt      = fetch_pc;
        tgt_adel = 1'b0;
        if (exc_req) begin
            tgt = EXC_VECTOR;
        end else if (redirect_req) begin
            tgt      = {redirect_pc[31:2], 2'b00};
            tgt_adel = |redirect_pc[1:0];
        end
    end

    // Reading is suppressed only while a live word sits unconsumed, so
    // the hold buffer can never be asked to take a second word.
    assign issue   = reset & (squash | ena | ~out_valid);
    assign capture = v1 & ~ena & ~squash;

    assign imem.imem_en   = issue;
    assign imem.imem_addr = tgt;

    always_comb begin
        state_nxt = EMPTY;
        if (issue) begin
            state_nxt = STREAM;
        end else if (capture) begin
            state_nxt = HOLD;
        end else if (hold_valid & ~ena & ~squash) begin
            state_nxt = HOLD;
        end
    end

    always_comb begin
        if_pc_out    = resp_pc;
        if_instr_out = 32'h0;
        if_adel      = 1'b0;
        case (state)
            HOLD: begin
                if_pc_out    = hold_pc;
                if_instr_out = hold_instr;
                if_adel      = hold_adel;
            end
            STREAM: begin
                if_pc_out    = resp_pc;
                if_instr_out = imem.imem_rdata;
                if_adel      = resp_adel;
            end
            default: begin
                if_pc_out    = resp_pc;
                if_instr_out = 32'h0;
                if_adel      = 1'b0;
            end
        endcase
        if (squash) begin
            if_instr_out = 32'h0;
        end
        if_valid = out_valid & ~squash;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc  <= RESET_PC;
            resp_pc   <= 32'h0;
            resp_adel <= 1'b0;
        end else if (issue) begin
            fetch_pc  <= tgt + 32'd4;
            resp_pc   <= tgt;
            resp_adel <= tgt_adel;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_instr <= 32'h0;
            hold_pc    <= 32'h0;
            hold_adel  <= 1'b0;
        end else if (capture) begin
            hold_instr <= imem.imem_rdata;
            hold_pc    <= resp_pc;
            hold_adel  <= resp_adel;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a synchronous IMEM model.
// IMEM word at byte address a holds a|1 (IMEM[i] = i*4+1).
module tb_if_fetch_stage;

    logic        clk;
    logic        reset;
    logic        ena;
    logic        redirect_req;
    logic [31:0] redirect_pc;
    logic        exc_req;
    logic [31:0] if_pc_out;
    logic [31:0] if_instr_out;
    logic        if_valid;
    logic        if_adel;

    int errs;
    int checks;

    if_fetch_stage_if bus ();

    if_fetch_stage dut (
        .clk          (clk),
        .reset        (reset),
        .ena          (ena),
        .redirect_req (redirect_req),
        .redirect_pc  (redirect_pc),
        .exc_req      (exc_req),
        .imem         (bus.master),
        .if_pc_out    (if_pc_out),
        .if_instr_out (if_instr_out),
        .if_valid     (if_valid),
        .if_adel      (if_adel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (bus.imem_en) begin
            bus.imem_rdata <= bus.imem_addr | 32'h1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic see(input string tag, input logic v, input logic [31:0] pc,
                       input logic [31:0] ins);
        chk({tag, "_valid"}, {31'h0, if_valid}, {31'h0, v});
        chk({tag, "_pc"}, if_pc_out, pc);
        chk({tag, "_instr"}, if_instr_out, ins);
    endtask

    task automatic req(input string tag, input logic en, input logic [31:0] a);
        chk({tag, "_en"}, {31'h0, bus.imem_en}, {31'h0, en});
        if (en) chk({tag, "_addr"}, bus.imem_addr, a);
    endtask

    initial begin
        errs         = 0;
        checks       = 0;
        reset        = 1'b0;
        ena          = 1'b0;
        redirect_req = 1'b0;
        redirect_pc  = 32'h0;
        exc_req      = 1'b0;

        // 1: reset then sequential stream
        repeat (3) @(negedge clk);
        #1;
        see("rst", 1'b0, 32'h0, 32'h0);
        req("rst", 1'b0, 32'h0);
        chk("rst_adel", {31'h0, if_adel}, 32'h0);

        @(negedge clk); reset = 1'b1; ena = 1'b1; #1;
        see("t1c0", 1'b0, 32'h0, 32'h0);
        req("t1c0", 1'b1, 32'h0);
        @(negedge clk); #1;
        see("t1c1", 1'b1, 32'h0, 32'h1);
        req("t1c1", 1'b1, 32'h4);
        @(negedge clk); #1;
        see("t1c2", 1'b1, 32'h4, 32'h5);
        req("t1c2", 1'b1, 32'h8);

        // 2: stall for 3 cycles on pc 0x8
        @(negedge clk); ena = 1'b0; #1;
        see("t2s0", 1'b1, 32'h8, 32'h9);
        req("t2s0", 1'b0, 32'h0);
        @(negedge clk); #1;
        see("t2s1", 1'b1, 32'h8, 32'h9);
        req("t2s1", 1'b0, 32'h0);
        @(negedge clk); #1;
        see("t2s2", 1'b1, 32'h8, 32'h9);
        req("t2s2", 1'b0, 32'h0);
        @(negedge clk); ena = 1'b1; #1;
        see("t2go", 1'b1, 32'h8, 32'h9);
        req("t2go", 1'b1, 32'hC);
        @(negedge clk); #1;
        see("t2nx", 1'b1, 32'hC, 32'hD);

        // 3: get into HOLD at pc 0x8, then redirect to 0x40
        @(negedge clk); redirect_req = 1'b1; redirect_pc = 32'h8; #1;
        req("t3r0", 1'b1, 32'h8);
        @(negedge clk); redirect_req = 1'b0; ena = 1'b0; #1;
        see("t3st", 1'b1, 32'h8, 32'h9);
        @(negedge clk); redirect_req = 1'b1; redirect_pc = 32'h40; #1;
        chk("t3sq_valid", {31'h0, if_valid}, 32'h0);
        chk("t3sq_instr", if_instr_out, 32'h0);
        req("t3sq", 1'b1, 32'h40);
        @(negedge clk); redirect_req = 1'b0; ena = 1'b1; #1;
        see("t3tg", 1'b1, 32'h40, 32'h41);
        @(negedge clk); #1;
        see("t3nx", 1'b1, 32'h44, 32'h45);

        // 4: exception wins over redirect
        @(negedge clk); exc_req = 1'b1; redirect_req = 1'b1; redirect_pc = 32'h80; #1;
        chk("t4_valid", {31'h0, if_valid}, 32'h0);
        req("t4", 1'b1, 32'h4);
        @(negedge clk); exc_req = 1'b0; redirect_req = 1'b0; #1;
        see("t4a", 1'b1, 32'h4, 32'h5);
        @(negedge clk); #1;
        see("t4b", 1'b1, 32'h8, 32'h9);

        // 5: misaligned redirect
        @(negedge clk); redirect_req = 1'b1; redirect_pc = 32'h102; #1;
        req("t5", 1'b1, 32'h100);
        @(negedge clk); redirect_req = 1'b0; #1;
        see("t5a", 1'b1, 32'h100, 32'h101);
        chk("t5a_adel", {31'h0, if_adel}, 32'h1);
        @(negedge clk); ena = 1'b0; #1;
        see("t5b", 1'b1, 32'h104, 32'h105);
        chk("t5b_adel", {31'h0, if_adel}, 32'h0);

        // 6: async reset while in HOLD, restart, PC wrap
        @(negedge clk); #1;
        see("t6h", 1'b1, 32'h104, 32'h105);
        req("t6h", 1'b0, 32'h0);
        reset = 1'b0; #1;
        chk("t6r_valid", {31'h0, if_valid}, 32'h0);
        chk("t6r_en", {31'h0, bus.imem_en}, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1; ena = 1'b1; #1;
        req("t6rel", 1'b1, 32'h0);
        @(negedge clk); #1;
        see("t6p0", 1'b1, 32'h0, 32'h1);
        @(negedge clk); redirect_req = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
        req("t6w0", 1'b1, 32'hFFFF_FFFC);
        @(negedge clk); redirect_req = 1'b0; #1;
        see("t6w1", 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFD);
        req("t6w1", 1'b1, 32'h0);
        @(negedge clk); #1;
        see("t6w2", 1'b1, 32'h0, 32'h1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
